mem_bus_ctrl: RTL and testbench

Bus cycle controller between the m6809 core's memory request port and the external async memories: the boot ROM and the external RAM.
- Decodes each CPU request to ROM or RAM.
- Drives the memory select/address/data lines and holds them stable for a parameterised number of wait cycles.
- Registers the read data and returns a single-cycle acknowledge to the core.
- The boot ROM is combinational, 16 bytes, selected by sel with address a[3:0]; it holds the reset vector at offsets E/F.

---
 rtl/mem_bus_ctrl.sv | 136 +++++++++++++
 tb/tb_mem_bus_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// Bus cycle controller between the m6809 memory request port and the external
// asynchronous boot ROM / RAM: decodes, holds the bus for N wait cycles, acks.
module mem_bus_ctrl #(
    parameter logic [15:0] ROM_BASE = 16'hFFF0,
    parameter int unsigned ROM_WAIT = 1,
    parameter int unsigned RAM_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_err,
    output logic        rom_sel,
    output logic [3:0]  rom_a,
    input  logic [7:0]  rom_dout,
    output logic        ram_sel,
    output logic        ram_we,
    output logic [15:0] ram_a,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout
);

    typedef enum logic [1:0] {
        IDLE,
        ROM_ACC,
        RAM_ACC,
        ERR
    } state_t;

    localparam logic [3:0] ROM_WAIT_C = 4'(ROM_WAIT);
    localparam logic [3:0] RAM_WAIT_C = 4'(RAM_WAIT);

    state_t      state_q;
    logic [3:0]  wait_cnt_q;
    logic        ack_q;
    logic        err_q;
    logic [7:0]  rdata_q;
    logic        rom_sel_q;
    logic [3:0]  rom_a_q;
    logic        ram_sel_q;
    logic        ram_we_q;
    logic [15:0] ram_a_q;
    logic [7:0]  ram_din_q;
    logic        rom_hit;

    assign rom_hit = (cpu_addr[15:4] == ROM_BASE[15:4]);

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: outputs are registers with async reset, so selects drop the
            // instant rst rises rather than at the next clock.
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 8'h00;
            rom_sel_q  <= 1'b0;
            rom_a_q    <= 4'd0;
            ram_sel_q  <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_a_q    <= 16'h0000;
            ram_din_q  <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    // The ack cycle is spent in IDLE; a still-high req is not a new request yet.
                    if (cpu_req && !ack_q) begin
                        if (rom_hit && !cpu_we) begin
                            state_q    <= ROM_ACC;
                            rom_sel_q  <= 1'b1;
                            rom_a_q    <= cpu_addr[3:0];
                            wait_cnt_q <= ROM_WAIT_C;
                        end else if (rom_hit) begin
                            state_q <= ERR;
                        end else begin
                            state_q    <= RAM_ACC;
                            ram_sel_q  <= 1'b1;
                            ram_we_q   <= cpu_we;
                            ram_a_q    <= cpu_addr;
                            ram_din_q  <= cpu_wdata;
                            wait_cnt_q <= RAM_WAIT_C;
                        end
                    end
                end
                ROM_ACC: begin
                    if (wait_cnt_q == 4'd0) begin
                        rdata_q   <= rom_dout;
                        ack_q     <= 1'b1;
                        rom_sel_q <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                RAM_ACC: begin
                    if (wait_cnt_q == 4'd0) begin
                        if (!ram_we_q) begin
                            rdata_q <= ram_dout;
                        end
                        ack_q     <= 1'b1;
                        ram_sel_q <= 1'b0;
                        ram_we_q  <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                ERR: begin
                    ack_q   <= 1'b1;
                    err_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_ack   = ack_q;
    assign cpu_err   = err_q;
    assign cpu_rdata = rdata_q;
    assign rom_sel   = rom_sel_q;
    assign rom_a     = rom_a_q;
    assign ram_sel   = ram_sel_q;
    assign ram_we    = ram_we_q;
    assign ram_a     = ram_a_q;
    assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed vector table, reset-abort
// sequence, then random transactions against a transaction-level model.
module tb_mem_bus_ctrl;

    localparam int ROM_WAIT = 1;
    localparam int RAM_WAIT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_err;
    logic        rom_sel;
    logic [3:0]  rom_a;
    logic [7:0]  rom_dout;
    logic        ram_sel;
    logic        ram_we;
    logic [15:0] ram_a;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;

    mem_bus_ctrl #(
        .ROM_BASE (16'hFFF0),
        .ROM_WAIT (ROM_WAIT),
        .RAM_WAIT (RAM_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
        .rom_sel   (rom_sel),
        .rom_a     (rom_a),
        .rom_dout  (rom_dout),
        .ram_sel   (ram_sel),
        .ram_we    (ram_we),
        .ram_a     (ram_a),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    // Boot ROM image (reset vector 0xFFF0 at offsets E/F) and external RAM.
    logic [7:0] rom_img [16] = '{8'h4F, 8'h4C, 8'h21, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A,
                                 8'hBC, 8'hDE, 8'h01, 8'h23, 8'h45, 8'h67, 8'hFF, 8'hF0};
    logic [7:0] ram_mem [65536];

    function automatic logic [7:0] init_pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    initial for (int i = 0; i < 65536; i++) ram_mem[i] = init_pat(16'(i));

    assign rom_dout = rom_sel ? rom_img[rom_a] : 8'h00;
    assign ram_dout = ram_mem[ram_a];
    always @(posedge clk) if (ram_sel && ram_we) ram_mem[ram_a] <= ram_din;

    int checks = 0;
    int errors = 0;
    int ack_seen = 0;
    int n_txn = 0;

    always @(negedge clk) if (cpu_ack) ack_seen++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic        keep;
        logic [7:0]  rd;
        logic        err;
        int          lat;
        int          rom_cyc;
        int          ram_cyc;
        int          we_cyc;
    } vec_t;

    typedef struct {
        logic       got;
        logic [7:0] rd;
        logic       err;
        int         lat;
        int         rom_cyc;
        int         ram_cyc;
        int         we_cyc;
        int         bad;
        int         both;
        int         stray;
    } res_t;

    function automatic vec_t mk(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                                input logic keep, input logic [7:0] rd, input logic err,
                                input int lat, input int romc, input int ramc, input int wec);
        vec_t v;
        v.we = we; v.addr = addr; v.wd = wd; v.keep = keep; v.rd = rd; v.err = err;
        v.lat = lat; v.rom_cyc = romc; v.ram_cyc = ramc; v.we_cyc = wec;
        return v;
    endfunction

    // Transaction-level reference: what each access should look like on the bus.
    logic [7:0] shadow [logic [15:0]];
    logic [7:0] m_rdata = 8'h00;
    logic       prev_keep = 1'b0;

    task automatic model_step(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                              input logic keep, output vec_t e);
        e = mk(we, addr, wd, keep, 8'h00, 1'b0, 0, 0, 0, 0);
        if (addr >= 16'hFFF0 && we) begin
            e.err = 1'b1;
            e.lat = 2;
        end else if (addr >= 16'hFFF0) begin
            m_rdata   = rom_img[addr[3:0]];
            e.lat     = ROM_WAIT + 2;
            e.rom_cyc = ROM_WAIT + 1;
        end else begin
            e.lat     = RAM_WAIT + 2;
            e.ram_cyc = RAM_WAIT + 1;
            if (we) begin
                shadow[addr] = wd;
                e.we_cyc     = RAM_WAIT + 1;
            end else begin
                m_rdata = shadow.exists(addr) ? shadow[addr] : init_pat(addr);
            end
        end
        // Starting while the previous ack is still showing costs one cycle.
        if (prev_keep) e.lat = e.lat + 1;
        e.rd = m_rdata;
    endtask

    // Called just after a negedge. Counts cycles until ack, scrambling cpu_*
    // once the request has been accepted to prove they are ignored.
    task automatic access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                          input logic keep, output res_t r);
        int skip;
        r = '{got: 1'b0, rd: 8'h00, err: 1'b0, lat: 0, rom_cyc: 0, ram_cyc: 0,
              we_cyc: 0, bad: 0, both: 0, stray: 0};
        skip = prev_keep ? 1 : 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        n_txn++;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            r.lat = c;
            if (rom_sel) begin
                r.rom_cyc++;
                if (rom_a !== addr[3:0]) r.bad++;
            end
            if (ram_sel) begin
                r.ram_cyc++;
                if (ram_a !== addr || ram_we !== we || (we && ram_din !== wd)) r.bad++;
            end
            if (ram_we) r.we_cyc++;
            if (rom_sel && ram_sel) r.both++;
            if (cpu_err && !cpu_ack) r.stray++;
            if (cpu_ack) begin
                r.got = 1'b1;
                r.rd  = cpu_rdata;
                r.err = cpu_err;
                break;
            end
            if (c > skip) begin
                cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
            end
        end
        prev_keep = keep;
        if (!keep || !r.got) begin
            cpu_req = 1'b0;
            prev_keep = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic compare(input string tag, input res_t r, input vec_t e);
        check($sformatf("%s.ack", tag), 32'(r.got), 32'd1);
        check($sformatf("%s.rdata", tag), 32'(r.rd), 32'(e.rd));
        check($sformatf("%s.err", tag), 32'(r.err), 32'(e.err));
        check($sformatf("%s.latency", tag), r.lat, e.lat);
        check($sformatf("%s.rom_sel_cycles", tag), r.rom_cyc, e.rom_cyc);
        check($sformatf("%s.ram_sel_cycles", tag), r.ram_cyc, e.ram_cyc);
        check($sformatf("%s.ram_we_cycles", tag), r.we_cyc, e.we_cyc);
        check($sformatf("%s.bus_lines_bad", tag), r.bad, 0);
        check($sformatf("%s.both_selects", tag), r.both, 0);
        check($sformatf("%s.stray_err", tag), r.stray, 0);
    endtask

    vec_t tbl [10];

    initial begin
        res_t r;
        vec_t e;
        int   ack_in_rst;

        // Directed vectors, ROM_WAIT=1 / RAM_WAIT=2, starting from reset.
        tbl[0] = mk(0, 16'hFFF0, 8'h00, 0, 8'h4F, 0, 3, 2, 0, 0);
        tbl[1] = mk(0, 16'hFFFE, 8'h00, 1, 8'hFF, 0, 3, 2, 0, 0);
        tbl[2] = mk(0, 16'hFFFF, 8'h00, 0, 8'hF0, 0, 4, 2, 0, 0);
        tbl[3] = mk(1, 16'hFFF3, 8'hAA, 0, 8'hF0, 1, 2, 0, 0, 0);
        tbl[4] = mk(0, 16'hFFF3, 8'h00, 0, 8'h12, 0, 3, 2, 0, 0);
        tbl[5] = mk(1, 16'h1000, 8'h5A, 0, 8'h12, 0, 4, 0, 3, 3);
        tbl[6] = mk(0, 16'h1000, 8'h00, 0, 8'h5A, 0, 4, 0, 3, 0);
        tbl[7] = mk(0, 16'hFFEF, 8'h00, 0, 8'h10, 0, 4, 0, 3, 0);
        tbl[8] = mk(0, 16'hFFF0, 8'h00, 0, 8'h4F, 0, 3, 2, 0, 0);
        tbl[9] = mk(0, 16'hFFF1, 8'h00, 0, 8'h4C, 0, 3, 2, 0, 0);

        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        repeat (2) @(negedge clk);
        check("reset.ctrl_outs", {27'd0, cpu_ack, cpu_err, rom_sel, ram_sel, ram_we}, 32'd0);
        check("reset.rdata", 32'(cpu_rdata), 32'd0);
        check("reset.addr_data", {rom_a, ram_a, ram_din}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            model_step(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].keep, e);
            access(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].keep, r);
            compare($sformatf("vec%0d", i), r, tbl[i]);
        end

        // Reset in the middle of a RAM wait cycle must abort with no ack.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2000; cpu_wdata = 8'h00;
        @(posedge clk);
        @(negedge clk);
        check("abort.ram_sel_before", 32'(ram_sel), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort.selects_dropped", {30'd0, rom_sel, ram_sel}, 32'd0);
        check("abort.rdata_cleared", 32'(cpu_rdata), 32'd0);
        cpu_req = 1'b0;
        ack_in_rst = 0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ack) ack_in_rst++;
        end
        rst = 1'b0;
        @(negedge clk);
        if (cpu_ack) ack_in_rst++;
        check("abort.no_ack", ack_in_rst, 0);
        m_rdata = 8'h00;
        prev_keep = 1'b0;
        model_step(tbl[9].we, tbl[9].addr, tbl[9].wd, tbl[9].keep, e);
        access(tbl[9].we, tbl[9].addr, tbl[9].wd, tbl[9].keep, r);
        compare("after_abort", r, tbl[9]);

        // Random mix of ROM reads/writes, boundary RAM and a small RAM window.
        for (int n = 0; n < 200; n++) begin
            logic        we;
            logic [15:0] addr;
            logic [7:0]  wd;
            logic        keep;
            case ($urandom_range(0, 3))
                0:       addr = {12'hFFF, 4'($urandom_range(0, 15))};
                1:       addr = {12'hFFE, 4'($urandom_range(0, 15))};
                default: addr = {12'h100, 4'($urandom_range(0, 15))};
            endcase
            we   = 1'($urandom_range(0, 1));
            wd   = 8'($urandom);
            keep = 1'($urandom_range(0, 1));
            model_step(we, addr, wd, keep, e);
            access(we, addr, wd, keep, r);
            compare($sformatf("rnd%0d", n), r, e);
        end
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        check("ack_count", ack_seen, n_txn);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
